// File: rtl/edge_detect_pkg.sv
// Shared mode encodings, parameter limits and the edge qualification helper.
// Latency: none (types, constants and a pure function only).
// Backpressure: none; optional input filter is selected by EDGE_DETECT_FILTER_EN.
package edge_detect_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 32;
    localparam int COUNT_W_MIN  = 2;
    localparam int COUNT_W_MAX  = 16;
    localparam int FILTER_MIN   = 1;
    localparam int FILTER_MAX   = 255;
    // Wide enough to hold FILTER_MAX.
    localparam int FILTER_CNT_W = 8;

    // True when the pulse present this cycle is one the channel mode asks for.
    function automatic logic qualify(input logic [1:0] sel, input logic pos, input logic neg);
        mode_e m;
        m = mode_e'(sel);
        return (pos && (m == MODE_RISE || m == MODE_BOTH)) ||
               (neg && (m == MODE_FALL || m == MODE_BOTH));
    endfunction

endpackage

// File: rtl/edge_detect_channel.sv
// One channel: 2-flop sync, optional stability filter (EDGE_DETECT_FILTER_EN), edge pulses, sticky flag, saturating counter.
// Latency: raw input to pulse 3 clocks, or 2+FILTER_CYCLES+1 clocks with the filter compiled in.
// Backpressure: none; every accepted edge is counted the cycle after its pulse.
module edge_detect_channel
    import edge_detect_pkg::*;
#(
    parameter int COUNT_W       = 8,
    parameter int FILTER_CYCLES = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               raw_in,
    input  logic [1:0]         mode,
    input  logic               event_clear,
    input  logic               count_clear,
    output logic               pos_edge,
    output logic               neg_edge,
    output logic               level,
    output logic               event_pending,
    output logic [COUNT_W-1:0] edge_count
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic               sync_meta;
    logic               sync_out;
    logic               level_q;
    logic               level_next;
    logic               pos_q;
    logic               neg_q;
    logic               pending_q;
    logic               qualified;
    logic [COUNT_W-1:0] count_q;

    // Two-flop synchroniser for the asynchronous input.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= raw_in;
            sync_out  <= sync_meta;
        end
    end

`ifdef EDGE_DETECT_FILTER_EN
    localparam logic [FILTER_CNT_W-1:0] FILTER_TARGET = FILTER_CNT_W'(FILTER_CYCLES);

    logic [FILTER_CNT_W-1:0] filter_cnt;
    logic                    filter_done;

    // Once FILTER_CYCLES differing samples have been seen the level flips,
    // even if the input has just moved back: that run was long enough.
    assign filter_done = (filter_cnt == FILTER_TARGET);
    assign level_next  = level_q ^ filter_done;

    // Run length of consecutive synchronised samples that disagree with level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filter_cnt <= '0;
        end else if (filter_done || (sync_out == level_q)) begin
            filter_cnt <= '0;
        end else begin
            filter_cnt <= filter_cnt + 1'b1;
        end
    end
`else
    // Filter depth has no effect in this build.
    localparam int unused_filter_cycles = FILTER_CYCLES;

    assign level_next = sync_out;
`endif

    // Accepted level plus one-cycle pulses on each change of it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            level_q <= level_next;
            pos_q   <= level_next & ~level_q;
            neg_q   <= ~level_next & level_q;
        end
    end

    // Mode is looked at only while a pulse is present, so mode changes never create events.
    assign qualified = qualify(mode, pos_q, neg_q);

    // Sticky event flag; a new event in the clearing cycle keeps it set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= qualified | (pending_q & ~event_clear);
        end
    end

    // Saturating event counter; a clear coinciding with an event leaves 1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (count_clear) begin
            count_q <= {{(COUNT_W-1){1'b0}}, qualified};
        end else if (qualified && (count_q != COUNT_MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign pos_edge      = pos_q;
    assign neg_edge      = neg_q;
    assign level         = level_q;
    assign event_pending = pending_q;
    assign edge_count    = count_q;

endmodule

// File: rtl/multi_edge_detect.sv
// Array of CHANNELS independent edge detectors with per-channel mode, flag and counter; filter via EDGE_DETECT_FILTER_EN.
// Latency: 3 clocks input to pulse (2+FILTER_CYCLES+1 with the filter); flag/count update one clock after the pulse.
// Backpressure: none; channels never arbitrate or stall each other.
module multi_edge_detect
    import edge_detect_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int COUNT_W       = 8,
    parameter int FILTER_CYCLES = 3
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [CHANNELS-1:0]         digital_in,
    input  logic [2*CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]         event_clear,
    input  logic [CHANNELS-1:0]         count_clear,
    output logic [CHANNELS-1:0]         pos_edge,
    output logic [CHANNELS-1:0]         neg_edge,
    output logic [CHANNELS-1:0]         level,
    output logic [CHANNELS-1:0]         event_pending,
    output logic [COUNT_W*CHANNELS-1:0] edge_count
);

    // Reject out-of-range configurations at elaboration.
    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
        $error("multi_edge_detect: CHANNELS out of range");
    end
    if (COUNT_W < COUNT_W_MIN || COUNT_W > COUNT_W_MAX) begin : g_bad_count_w
        $error("multi_edge_detect: COUNT_W out of range");
    end
`ifdef EDGE_DETECT_FILTER_EN
    if (FILTER_CYCLES < FILTER_MIN || FILTER_CYCLES > FILTER_MAX) begin : g_bad_filter
        $error("multi_edge_detect: FILTER_CYCLES out of range");
    end
`endif

    // One fully independent channel per input bit.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        edge_detect_channel #(
            .COUNT_W       (COUNT_W),
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_ch (
            .clock         (clock),
            .reset_n       (reset_n),
            .raw_in        (digital_in[i]),
            .mode          (mode[2*i +: 2]),
            .event_clear   (event_clear[i]),
            .count_clear   (count_clear[i]),
            .pos_edge      (pos_edge[i]),
            .neg_edge      (neg_edge[i]),
            .level         (level[i]),
            .event_pending (event_pending[i]),
            .edge_count    (edge_count[COUNT_W*i +: COUNT_W])
        );
    end

endmodule

// File: tb/tb_multi_edge_detect.sv
// Bench for multi_edge_detect: directed scenarios plus random traffic against a behavioural model.
// Latency: model steps on every rising edge, outputs compared on the falling edge.
// Backpressure: none; honours EDGE_DETECT_FILTER_EN for expected latencies.
module tb_multi_edge_detect;
    import edge_detect_pkg::*;

    localparam int CH   = 4;
    localparam int CW   = 8;
    localparam int FC   = 3;
    localparam int CMAX = (1 << CW) - 1;
`ifdef EDGE_DETECT_FILTER_EN
    localparam int LAT            = FC + 2;   // edges after the sampling edge until level flips
    localparam int GLITCH_PULSES  = 0;
`else
    localparam int LAT            = 2;
    localparam int GLITCH_PULSES  = 1;
`endif

    logic               clock = 1'b0;
    logic               reset_n;
    logic [CH-1:0]      din, ev_clr, cnt_clr;
    logic [2*CH-1:0]    mode;
    logic [CH-1:0]      pos, neg, lvl, pend;
    logic [CW*CH-1:0]   cnt;

    logic               din2, ev_clr2, cnt_clr2;
    logic [1:0]         mode2;
    logic               pos2, neg2, lvl2, pend2;
    logic [1:0]         cnt2;

    int n_cmp;
    int n_bad;

    always #5 clock = ~clock;

    multi_edge_detect #(.CHANNELS(CH), .COUNT_W(CW), .FILTER_CYCLES(FC)) dut (
        .clock(clock), .reset_n(reset_n), .digital_in(din), .mode(mode),
        .event_clear(ev_clr), .count_clear(cnt_clr), .pos_edge(pos), .neg_edge(neg),
        .level(lvl), .event_pending(pend), .edge_count(cnt)
    );

    multi_edge_detect #(.CHANNELS(1), .COUNT_W(2), .FILTER_CYCLES(FC)) dut2 (
        .clock(clock), .reset_n(reset_n), .digital_in(din2), .mode(mode2),
        .event_clear(ev_clr2), .count_clear(cnt_clr2), .pos_edge(pos2), .neg_edge(neg2),
        .level(lvl2), .event_pending(pend2), .edge_count(cnt2)
    );

    // Behavioural model of the main instance.
    logic [CH-1:0] m_s1, m_s2, m_level, m_pos, m_neg, m_pend;
    int            m_cnt [CH];
    int            m_run [CH];
    bit            m_due [CH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_pos = '0; m_neg = '0; m_pend = '0;
        for (int c = 0; c < CH; c++) begin
            m_cnt[c] = 0; m_run[c] = 0; m_due[c] = 0;
        end
    endtask

    task automatic model_edge();
        logic [CH-1:0] lvl_n;
        logic          q;
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int c = 0; c < CH; c++) begin
            q = (m_pos[c] && mode[2*c]) || (m_neg[c] && mode[2*c+1]);
            if (cnt_clr[c]) m_cnt[c] = q ? 1 : 0;
            else if (q && m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
            m_pend[c] = q || (m_pend[c] && !ev_clr[c]);
`ifdef EDGE_DETECT_FILTER_EN
            lvl_n[c] = m_level[c];
            if (m_due[c]) begin
                lvl_n[c] = !m_level[c];
                m_due[c] = 0;
                m_run[c] = 0;
            end else if (m_s2[c] != m_level[c]) begin
                m_run[c] = m_run[c] + 1;
                if (m_run[c] == FC) m_due[c] = 1;
            end else begin
                m_run[c] = 0;
            end
`else
            lvl_n[c] = m_s2[c];
`endif
        end
        m_pos   = lvl_n & ~m_level;
        m_neg   = ~lvl_n & m_level;
        m_level = lvl_n;
        m_s2    = m_s1;
        m_s1    = din;
    endtask

    task automatic check_all();
        logic [CW*CH-1:0] ec;
        for (int c = 0; c < CH; c++) ec[CW*c +: CW] = CW'(m_cnt[c]);
        chk("level", 64'(lvl), 64'(m_level));
        chk("pos_edge", 64'(pos), 64'(m_pos));
        chk("neg_edge", 64'(neg), 64'(m_neg));
        chk("event_pending", 64'(pend), 64'(m_pend));
        chk("edge_count", 64'(cnt), 64'(ec));
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            model_edge();
            @(negedge clock);
            check_all();
        end
    endtask

    task automatic run_count(input int n, input int c, output int np, output int nn);
        np = 0;
        nn = 0;
        repeat (n) begin
            step();
            np += int'(pos[c]);
            nn += int'(neg[c]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  a, b, c2, d, idx, at;
        bit  found;
        n_cmp = 0; n_bad = 0;
        din = '0; mode = '0; ev_clr = '0; cnt_clr = '0;
        din2 = 1'b0; mode2 = MODE_BOTH; ev_clr2 = 1'b0; cnt_clr2 = 1'b0;
        reset_n = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_level", 64'(lvl), 64'd0);
        chk("rst_pos", 64'(pos), 64'd0);
        chk("rst_neg", 64'(neg), 64'd0);
        chk("rst_pending", 64'(pend), 64'd0);
        chk("rst_count", 64'(cnt), 64'd0);
        chk("rst_count2", 64'(cnt2), 64'd0);
        reset_n = 1'b1;
        step(3);

        // ch0 rising input: pulse exactly LAT edges after the sampling edge
        din[0] = 1'b1;
        for (int j = 0; j <= LAT + 1; j++) begin
            step();
            chk("lat_pos0", 64'(pos[0]), 64'(j == LAT));
            chk("lat_level0", 64'(lvl[0]), 64'(j >= LAT));
        end
        din[0] = 1'b0;
        step(LAT + 3);

        // ch1 short glitch, then a long pulse
        din[1] = 1'b1;
        run_count(2, 1, a, b);
        din[1] = 1'b0;
        run_count(LAT + FC + 4, 1, c2, d);
        chk("glitch_pos1", 64'(a + c2), 64'(GLITCH_PULSES));
        chk("glitch_neg1", 64'(b + d), 64'(GLITCH_PULSES));
        din[1] = 1'b1;
        run_count(5, 1, a, b);
        din[1] = 1'b0;
        run_count(LAT + FC + 6, 1, c2, d);
        chk("long_pos1", 64'(a + c2), 64'd1);
        chk("long_neg1", 64'(b + d), 64'd1);

        // ch2 fall-only qualification
        mode[5:4] = MODE_FALL;
        repeat (4) begin
            din[2] = ~din[2];
            step(LAT + 3);
        end
        chk("fall_count2", 64'(cnt[2*CW +: CW]), 64'd2);
        chk("fall_pending2", 64'(pend[2]), 64'd1);
        din[2] = 1'b1;
        step(LAT + 3);
        din[2] = 1'b0;
        found = 0;
        for (int j = 0; j < LAT + FC + 4 && !found; j++) begin
            step();
            if (neg[2]) found = 1;
        end
        chk("fall_seen2", 64'(found), 64'd1);
        ev_clr[2] = 1'b1;
        step();
        ev_clr[2] = 1'b0;
        chk("set_wins2", 64'(pend[2]), 64'd1);
        chk("fall_count2b", 64'(cnt[2*CW +: CW]), 64'd3);
        ev_clr[2] = 1'b1;
        step();
        ev_clr[2] = 1'b0;
        chk("clear2", 64'(pend[2]), 64'd0);

        // 2-bit counter saturation and clear-with-edge
        repeat (6) begin
            din2 = ~din2;
            step(LAT + 3);
        end
        chk("sat_count", 64'(cnt2), 64'd3);
        chk("sat_pending", 64'(pend2), 64'd1);
        din2 = ~din2;
        found = 0;
        for (int j = 0; j < LAT + FC + 4 && !found; j++) begin
            step();
            if (pos2 || neg2) found = 1;
        end
        chk("dut2_edge_seen", 64'(found), 64'd1);
        cnt_clr2 = 1'b1;
        step();
        cnt_clr2 = 1'b0;
        chk("clr_with_edge", 64'(cnt2), 64'd1);
        cnt_clr2 = 1'b1;
        step();
        cnt_clr2 = 1'b0;
        chk("clr_alone", 64'(cnt2), 64'd0);

        // Reset while an edge on ch3 is in flight, input held high
        din[3] = 1'b1;
        step(LAT - 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_level", 64'(lvl), 64'd0);
        chk("midrst_pos", 64'(pos), 64'd0);
        chk("midrst_neg", 64'(neg), 64'd0);
        chk("midrst_pending", 64'(pend), 64'd0);
        chk("midrst_count", 64'(cnt), 64'd0);
        model_reset();
        step(2);
        reset_n = 1'b1;
        a = 0;
        at = -1;
        for (int j = 0; j < LAT + 4; j++) begin
            step();
            if (pos[3]) begin
                a++;
                at = j;
            end
        end
        chk("post_rst_pulses3", 64'(a), 64'd1);
        chk("post_rst_lat3", 64'(at), 64'(LAT));

        // Random traffic against the model
        repeat (600) begin
            if ($urandom_range(5) == 0) begin
                idx = $urandom_range(CH - 1);
                din[idx] = ~din[idx];
            end
            if ($urandom_range(19) == 0) mode = (2*CH)'($urandom);
            for (int c = 0; c < CH; c++) begin
                ev_clr[c]  = ($urandom_range(7) == 0);
                cnt_clr[c] = ($urandom_range(15) == 0);
            end
            step();
        end
        ev_clr = '0;
        cnt_clr = '0;
        step(LAT + FC + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_edge_detect.md
MULTI_EDGE_DETECT -- requirements
Module: multi_edge_detect

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent input channels (1..32).
REQ-002 SHALL have parameter COUNT_W, default 8, width of each per-channel edge counter (2..16).
REQ-003 SHALL have parameter FILTER_CYCLES, default 3, input stability cycles before acceptance (1..255); used only when the filter is compiled in.
REQ-004 SHALL have port clock  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port digital_in  input  CHANNELS  raw asynchronous inputs, bit i = channel i.
REQ-007 SHALL have port mode  input  2*CHANNELS  per-channel qualify mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
REQ-008 SHALL have port event_clear  input  CHANNELS  per-channel one-cycle clear of event_pending.
REQ-009 SHALL have port count_clear  input  CHANNELS  per-channel one-cycle clear of edge_count.
REQ-010 SHALL have port pos_edge  output  CHANNELS  one-cycle registered rising-edge pulse, independent of mode.
REQ-011 SHALL have port neg_edge  output  CHANNELS  one-cycle registered falling-edge pulse, independent of mode.
REQ-012 SHALL have port level  output  CHANNELS  accepted (synchronised/filtered) input level.
REQ-013 SHALL have port event_pending  output  CHANNELS  sticky flag, set on a mode-qualified edge.
REQ-014 SHALL have port edge_count  output  COUNT_W*CHANNELS  per-channel saturating count of qualified edges, channel i at [COUNT_W*i +: COUNT_W].

Function
REQ-015 SHALL pass each digital_in bit through a two-flop synchroniser before any other use.
REQ-016 SHALL update level[i] from the synchroniser output (filter per REQ-028/029).
REQ-017 SHALL assert pos_edge[i] for exactly one cycle in the cycle after level[i] changes 0->1; neg_edge[i] likewise for 1->0; never both in one cycle.
REQ-018 SHALL give, without the filter, a latency of 3 clocks: input high before edge k -> pos_edge high between edges k+2 and k+3.
REQ-019 SHALL treat an edge as qualified when it is a pulse on pos_edge or neg_edge permitted by mode[i], sampled in the same cycle as the pulse.
REQ-020 SHALL set event_pending[i] on a qualified edge; event_clear[i] clears it next cycle; simultaneous set and clear -> set wins.
REQ-021 SHALL increment edge_count[i] by 1 per qualified edge, saturating at 2^COUNT_W-1 (no wrap).
REQ-022 SHALL, on count_clear[i] alone, load 0; with a simultaneous qualified edge, load 1.
REQ-023 SHALL make mode changes take effect on the next qualified edge; changing mode never generates pulses or flags.
REQ-024 SHALL keep channels fully independent; no cross-channel priority or arbitration.

Reset
REQ-025 SHALL, while reset_n is low, asynchronously force synchronisers, level, pos_edge, neg_edge, event_pending, edge_count and filter counters to 0.
REQ-026 SHALL, after reset release with an input held high, report a rising edge after normal latency (reset level is 0).
REQ-027 SHALL, on reset mid-pulse or mid-filter, discard the in-flight edge with no pulse after release other than per REQ-026.

Configuration
REQ-028 SHALL, with EDGE_DETECT_FILTER_EN defined, include per-channel filter: counter cleared when synchroniser equals level, incremented when they differ; level toggles when FILTER_CYCLES consecutive differing samples are seen; latency becomes 2+FILTER_CYCLES+1 clocks.
REQ-029 SHALL, without EDGE_DETECT_FILTER_EN, copy synchroniser output to level each cycle with no filter counter logic; FILTER_CYCLES ignored.

Structure
REQ-030 SHALL put mode encodings (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH) and width limits in package edge_detect_pkg.
REQ-031 SHALL implement one channel in sub-module edge_detect_channel (sync, filter, pulses, flag, counter), instantiated CHANNELS times by generate.

Verification
REQ-032 SHALL cover: CHANNELS=4, no filter, ch0 0->1 at edge 10 -> pos_edge[0] high only between edges 12 and 13, level[0]=1 from 12.
REQ-033 SHALL cover: filter on, FILTER_CYCLES=3, ch1 glitch high 2 cycles -> no pulse, level[1] stays 0; high 5 cycles -> one pos_edge, one neg_edge.
REQ-034 SHALL cover: mode ch2=10, 4 toggles -> edge_count[2]=2, event_pending[2]=1; event_clear with coincident fall -> flag stays 1.
REQ-035 SHALL cover: COUNT_W=2, mode=11, 6 edges -> edge_count=3; count_clear with coincident edge -> 1.
REQ-036 SHALL cover: input high, reset_n pulsed low mid-filter -> all outputs 0 during reset, one pos_edge after release latency.
